float_mult: RTL and testbench

- Pipelined IEEE-754 binary32 multiplier used by the CNN datapath's convolution/MAC units.
- Computes product = floatA × floatB.
- Normal operands only; subnormal inputs and outputs are flushed to zero.
- Two-stage registered pipeline with a valid strobe; no backpressure.

---
 rtl/float_pkg.sv | 38 +++
 rtl/float_mult_round.sv | 63 ++++++
 rtl/float_mult.sv | 84 ++++++++
 tb/tb_float_mult.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared binary32 definitions for the float_mult pipeline: field widths,
// special encodings, the field-level struct and operand classification.
package float_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;
   localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_t;

   // Subnormals classify as zero so they are flushed on entry.
   function automatic fp_class_t fp_classify(input fp32_t f);
      fp_class_t c;
      if (f.exp == '0)
         c = FP_ZERO;
      else if (f.exp == '1)
         c = (f.frac == '0) ? FP_INF : FP_NAN;
      else
         c = FP_NORM;
      return c;
   endfunction

endpackage

// File: rtl/float_mult_round.sv
// Combinational stage 2: normalize, round (truncate, or RNE with FLOAT_MULT_ROUND_NEAREST_EN),
// range-check and pack; special-operand classes override the arithmetic result.
module float_mult_round
   import float_pkg::*;
(
   input  logic               i_sign,
   input  logic signed [9:0]  i_exp,
   input  logic [47:0]        i_mant,
   input  fp_class_t          i_cls_a,
   input  fp_class_t          i_cls_b,
   output logic [FP_W-1:0]    o_result
);

   logic                w_norm;
   logic [FRAC_W-1:0]   w_frac;
   logic signed [9:0]   w_exp_n;
   logic [FRAC_W-1:0]   w_frac_r;
   logic signed [9:0]   w_exp_r;

   assign w_norm  = i_mant[47];
   assign w_frac  = w_norm ? i_mant[46:24] : i_mant[45:23];
   assign w_exp_n = w_norm ? (i_exp + 10'sd1) : i_exp;

`ifdef FLOAT_MULT_ROUND_NEAREST_EN
   logic          w_guard;
   logic          w_sticky;
   logic          w_rnd_up;
   logic [23:0]   w_frac_sum;

   assign w_guard    = w_norm ? i_mant[23] : i_mant[22];
   assign w_sticky   = w_norm ? (|i_mant[22:0]) : (|i_mant[21:0]);
   // Ties go to the even mantissa: round up only when the kept LSB is 1.
   assign w_rnd_up   = w_guard & (w_sticky | w_frac[0]);
   assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_rnd_up};
   assign w_frac_r   = w_frac_sum[23] ? '0 : w_frac_sum[22:0];
   assign w_exp_r    = w_frac_sum[23] ? (w_exp_n + 10'sd1) : w_exp_n;
`else
   logic w_unused_dropped;

   assign w_unused_dropped = ^i_mant[22:0];
   assign w_frac_r         = w_frac;
   assign w_exp_r          = w_exp_n;
`endif

   always_comb begin
      o_result = FP_POS_ZERO;
      if ((i_cls_a == FP_NAN) || (i_cls_b == FP_NAN) ||
          ((i_cls_a == FP_INF) && (i_cls_b == FP_ZERO)) ||
          ((i_cls_a == FP_ZERO) && (i_cls_b == FP_INF)))
         o_result = FP_QNAN;
      else if ((i_cls_a == FP_INF) || (i_cls_b == FP_INF))
         o_result = {i_sign, 8'hFF, 23'd0};
      else if ((i_cls_a == FP_ZERO) || (i_cls_b == FP_ZERO))
         o_result = FP_POS_ZERO;
      else if (w_exp_r >= 10'sd255)
         o_result = {i_sign, 8'hFF, 23'd0};
      else if (w_exp_r <= 10'sd0)
         o_result = FP_POS_ZERO;
      else
         o_result = {i_sign, w_exp_r[7:0], w_frac_r};
   end

endmodule

// File: rtl/float_mult.sv
// Pipelined binary32 multiplier: operand capture, stage 1 (sign/exponent/mantissa product), stage 2
// (normalize/round/pack); product appears 2 edges after capture, no backpressure. Option: FLOAT_MULT_ROUND_NEAREST_EN.
module float_mult
   import float_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [FP_W-1:0]  floatA,
   input  logic [FP_W-1:0]  floatB,
   output logic             out_valid,
   output logic [FP_W-1:0]  product
);

   logic               r_in_vld;
   fp32_t              r_a;
   fp32_t              r_b;

   logic               r_s1_vld;
   logic               r_s1_sign;
   logic signed [9:0]  r_s1_exp;
   logic [47:0]        r_s1_mant;
   fp_class_t          r_s1_cls_a;
   fp_class_t          r_s1_cls_b;

   logic               r_out_vld;
   logic [FP_W-1:0]    r_product;

   logic signed [9:0]  w_exp_sum;
   logic [47:0]        w_mant_prod;
   logic [FP_W-1:0]    w_result;

   assign w_exp_sum   = $signed({2'b00, r_a.exp}) + $signed({2'b00, r_b.exp}) - 10'sd127;
   assign w_mant_prod = 48'({1'b1, r_a.frac}) * 48'({1'b1, r_b.frac});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_vld   <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_exp   <= '0;
         r_s1_mant  <= '0;
         r_s1_cls_a <= FP_ZERO;
         r_s1_cls_b <= FP_ZERO;
         r_out_vld  <= 1'b0;
         r_product  <= '0;
      end else begin
         r_in_vld <= in_valid;
         if (in_valid) begin
            r_a <= floatA;
            r_b <= floatB;
         end

         r_s1_vld <= r_in_vld;
         if (r_in_vld) begin
            r_s1_sign  <= r_a.sign ^ r_b.sign;
            r_s1_exp   <= w_exp_sum;
            r_s1_mant  <= w_mant_prod;
            r_s1_cls_a <= fp_classify(r_a);
            r_s1_cls_b <= fp_classify(r_b);
         end

         // Product is held through bubbles; only out_valid marks it fresh.
         r_out_vld <= r_s1_vld;
         if (r_s1_vld)
            r_product <= w_result;
      end
   end

   float_mult_round u_round (
      .i_sign   (r_s1_sign),
      .i_exp    (r_s1_exp),
      .i_mant   (r_s1_mant),
      .i_cls_a  (r_s1_cls_a),
      .i_cls_b  (r_s1_cls_b),
      .o_result (w_result)
   );

   assign out_valid = r_out_vld;
   assign product   = r_product;

endmodule

// File: tb/tb_float_mult.sv
// Directed-vector bench for float_mult: table of hand-computed products,
// plus back-to-back streaming and reset-while-in-flight sequences.
module tb_float_mult;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] floatA;
   logic [31:0] floatB;
   logic        out_valid;
   logic [31:0] product;

   int checks;
   int errors;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] stream_a[4];
   logic [31:0] stream_b[4];
   logic [31:0] stream_e[4];

   float_mult dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .floatA    (floatA),
      .floatB    (floatB),
      .out_valid (out_valid),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0b required %0b", name, got, want);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h required %08h", name, got, want);
      end
   endtask

   // One isolated operation: drive before edge N, nothing after N+1, result after N+2.
   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
      @(negedge clk);
      in_valid = 1'b1;
      floatA   = a;
      floatB   = b;
      @(negedge clk);
      in_valid = 1'b0;
      floatA   = 32'hDEAD_BEEF;
      floatB   = 32'hDEAD_BEEF;
      @(negedge clk);
      check1({name, " early_vld"}, out_valid, 1'b0);
      @(negedge clk);
      check1({name, " vld"}, out_valid, 1'b1);
      check32(name, product, want);
      @(negedge clk);
      check1({name, " vld_drop"}, out_valid, 1'b0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      floatA   = '0;
      floatB   = '0;

      vecs.push_back('{"small_prod",  32'h39D844D0, 32'h350CEDBA, 32'h2F6E1CED});
      vecs.push_back('{"x_zero",      32'h39D844D0, 32'h00000000, 32'h00000000});
      vecs.push_back('{"neg2_zero",   32'hC0000000, 32'h00000000, 32'h00000000});
      vecs.push_back('{"two_three",   32'h40000000, 32'h40400000, 32'h40C00000});
      vecs.push_back('{"neg_mult",    32'hBFC00000, 32'h40000000, 32'hC0400000});
      vecs.push_back('{"one_one",     32'h3F800000, 32'h3F800000, 32'h3F800000});
      vecs.push_back('{"overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000});
      vecs.push_back('{"ovf_edge",    32'h7F000000, 32'h40000000, 32'h7F800000});
      vecs.push_back('{"max_norm",    32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF});
      vecs.push_back('{"underflow",   32'h00800000, 32'h00800000, 32'h00000000});
      vecs.push_back('{"unf_edge",    32'h00800000, 32'h3F000000, 32'h00000000});
      vecs.push_back('{"inf_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000});
      vecs.push_back('{"inf_subn",    32'h00000001, 32'h7F800000, 32'h7FC00000});
      vecs.push_back('{"ninf_two",    32'hFF800000, 32'h40000000, 32'hFF800000});
      vecs.push_back('{"inf_inf",     32'h7F800000, 32'h7F800000, 32'h7F800000});
      vecs.push_back('{"nan_one",     32'hFFC12345, 32'h3F800000, 32'h7FC00000});
      vecs.push_back('{"nan_zero",    32'h00000000, 32'h7F800001, 32'h7FC00000});
      vecs.push_back('{"subn_flush",  32'h00000001, 32'h7F7FFFFF, 32'h00000000});
`ifdef FLOAT_MULT_ROUND_NEAREST_EN
      vecs.push_back('{"round",       32'h3FC00001, 32'h3FC00000, 32'h40100001});
`else
      vecs.push_back('{"round",       32'h3FC00001, 32'h3FC00000, 32'h40100000});
`endif

      repeat (3) @(negedge clk);
      check1("reset out_valid", out_valid, 1'b0);
      check32("reset product", product, 32'h0);
      reset = 1'b0;

      foreach (vecs[i])
         run_one(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Four back-to-back operations; op k is visible after k+3 edges from op 0 drive.
      stream_a = '{32'h40000000, 32'hBFC00000, 32'h3F800000, 32'h7F000000};
      stream_b = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h7F000000};
      stream_e = '{32'h40C00000, 32'hC0400000, 32'h3F800000, 32'h7F800000};
      @(negedge clk);
      in_valid = 1'b1;
      floatA   = stream_a[0];
      floatB   = stream_b[0];
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc >= 3 && cyc <= 6) begin
            check1($sformatf("stream vld %0d", cyc), out_valid, 1'b1);
            check32($sformatf("stream op %0d", cyc - 3), product, stream_e[cyc - 3]);
         end else begin
            check1($sformatf("stream idle %0d", cyc), out_valid, 1'b0);
         end
         if (cyc < 4) begin
            in_valid = 1'b1;
            floatA   = stream_a[cyc];
            floatB   = stream_b[cyc];
         end else begin
            in_valid = 1'b0;
         end
      end
      check32("stream hold", product, stream_e[3]);

      // Reset with two operations in flight: nothing may emerge afterwards.
      @(negedge clk);
      in_valid = 1'b1;
      floatA   = 32'h40000000;
      floatB   = 32'h40400000;
      @(negedge clk);
      floatA   = 32'hBFC00000;
      floatB   = 32'h40000000;
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check1("midreset out_valid", out_valid, 1'b0);
      check32("midreset product", product, 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check1($sformatf("no_stale vld %0d", k), out_valid, 1'b0);
         check32($sformatf("no_stale prod %0d", k), product, 32'h0);
      end

      run_one("after_reset", 32'h40000000, 32'h40400000, 32'h40C00000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
